// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : funct3 codes, sequencer state encoding and byte-mask helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] funct);
    case (funct[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic funct_legal(input logic store, input logic [2:0] funct);
    if (store)
      return (funct == F3_SB) || (funct == F3_SH) || (funct == F3_SW);
    return !((funct == 3'b011) || (funct[2:1] == 2'b11));
  endfunction

  // An access crosses a word boundary when its bytes spill past lane 3.
  function automatic logic is_crossing(input logic [2:0] funct, input logic [1:0] off);
    return ((funct[1:0] == 2'b01) && (off == 2'b11)) ||
           ((funct[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_req_if / lsu_mem_if : core-side request/response and memory-port bundles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_store, req_funct, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_store, req_funct, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_extend.sv
// ---------------------------------------------------------------------------
// lsu_extend : realigns merged read data by byte offset and sign/zero-extends
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_extend
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct,
  output logic [31:0] result
);

  logic [31:0] aligned;

  assign aligned = 32'(data >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (funct)
      F3_LB:   result = {{24{aligned[7]}}, aligned[7:0]};
      F3_LH:   result = {{16{aligned[15]}}, aligned[15:0]};
      F3_LW:   result = aligned;
      F3_LBU:  result = {24'b0, aligned[7:0]};
      F3_LHU:  result = {16'b0, aligned[15:0]};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_sequencer : one-at-a-time load/store sequencer onto a word-wide memory port
// Optional: LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two beats
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic      clk,
  input  logic      resetn,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_t        state;
  logic              st_store;
  logic [2:0]        st_funct;
  logic [1:0]        st_off;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        in_off;
  logic [3:0]        strb_lo;
  logic [31:0]       wdata_lo;
  logic [ADDR_W-1:0] word_addr;
  logic              bad_req;
  logic              timed_out;
  logic [63:0]       ext_in;
  logic [31:0]       ext_out;

  assign in_off    = req.req_addr[1:0];
  assign word_addr = {req.req_addr[ADDR_W-1:2], 2'b00};
  assign req.req_ready = (state == ST_IDLE);
  assign timed_out = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        st_cross;
  logic [3:0]  st_strb_hi;
  logic [31:0] st_wdata_hi;
  logic [31:0] lo;
  logic [7:0]  strb8;
  logic [63:0] wdata64;

  assign strb8    = {4'b0000, size_mask(req.req_funct)} << in_off;
  assign wdata64  = {32'b0, req.req_wdata} << {in_off, 3'b000};
  assign strb_lo  = strb8[3:0];
  assign wdata_lo = wdata64[31:0];
  assign bad_req  = !funct_legal(req.req_store, req.req_funct);
  // Second beat supplies the upper word; first-beat data waits in lo.
  assign ext_in   = (state == ST_ACC1) ? {mem.mem_rdata, lo} : {32'b0, mem.mem_rdata};
`else
  assign strb_lo  = size_mask(req.req_funct) << in_off;
  assign wdata_lo = req.req_wdata << {in_off, 3'b000};
  assign bad_req  = !funct_legal(req.req_store, req.req_funct) ||
                    is_crossing(req.req_funct, in_off);
  assign ext_in   = {32'b0, mem.mem_rdata};
`endif

  lsu_extend u_extend (
    .data   (ext_in),
    .off    (st_off),
    .funct  (st_funct),
    .result (ext_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      st_store      <= 1'b0;
      st_funct      <= '0;
      st_off        <= '0;
      cnt           <= '0;
      mem.mem_valid <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
      req.rsp_valid <= 1'b0;
      req.rsp_rdata <= '0;
      req.rsp_err   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      st_cross      <= 1'b0;
      st_strb_hi    <= '0;
      st_wdata_hi   <= '0;
      lo            <= '0;
`endif
    end else begin
      req.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            st_store <= req.req_store;
            st_funct <= req.req_funct;
            st_off   <= in_off;
            cnt      <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            st_cross    <= is_crossing(req.req_funct, in_off);
            st_strb_hi  <= strb8[7:4];
            st_wdata_hi <= wdata64[63:32];
`endif
            if (bad_req) begin
              state         <= ST_RESP;
              req.rsp_valid <= 1'b1;
              req.rsp_err   <= 1'b1;
              req.rsp_rdata <= '0;
            end else begin
              state         <= ST_ACC0;
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= word_addr;
              mem.mem_wstrb <= req.req_store ? strb_lo : 4'b0000;
              mem.mem_wdata <= req.req_store ? wdata_lo : 32'b0;
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (mem.mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if ((state == ST_ACC0) && st_cross) begin
              state         <= ST_ACC1;
              lo            <= mem.mem_rdata;
              cnt           <= '0;
              mem.mem_addr  <= mem.mem_addr + ADDR_W'(4);
              mem.mem_wstrb <= st_store ? st_strb_hi : 4'b0000;
              mem.mem_wdata <= st_store ? st_wdata_hi : 32'b0;
            end else
`endif
            begin
              state         <= ST_RESP;
              mem.mem_valid <= 1'b0;
              mem.mem_wstrb <= '0;
              req.rsp_valid <= 1'b1;
              req.rsp_err   <= 1'b0;
              req.rsp_rdata <= st_store ? 32'b0 : ext_out;
            end
          end else if (timed_out) begin
            state         <= ST_RESP;
            mem.mem_valid <= 1'b0;
            mem.mem_wstrb <= '0;
            req.rsp_valid <= 1'b1;
            req.rsp_err   <= 1'b1;
            req.rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
